// File: rtl/square_arb4.sv
// Four-requester front end sharing one radix-4 squarer: round-robin grant,
// one operation in flight, result held until the consumer accepts it.
module radix4_16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] sq
);

  // One partial product per base-4 digit of the multiplier.
  function automatic logic [W-1:0] digit_pp(input logic [W-1:0] x, input logic [1:0] d);
    case (d)
      2'd0:    return '0;
      2'd1:    return x;
      2'd2:    return x << 1;
      default: return x + (x << 1);
    endcase
  endfunction

  // Every partial product is truncated to W bits, so the sum is the square mod 2^W.
  always_comb begin
    sq = '0;
    for (int i = 0; i < W / 2; i++) begin
      sq = sq + (digit_pp(a, a[2*i +: 2]) << (2 * i));
    end
  end

endmodule

module square_arb4 #(
  parameter int W    = 16,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [1:0]        res_id,
  output logic [W-1:0]      res_data,
  input  logic              res_ready,
  output logic              busy,
  output logic [W-1:0]      done_cnt
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state_q, state_d;
  logic [1:0]     ptr_q;
  logic [1:0]     win;
  logic [1:0]     idx;
  logic           any_req;
  logic           grant_fire;
  logic           done_fire;
  logic [W-1:0]   ops [NREQ];
  logic [W-1:0]   op_p0;
  logic [1:0]     id_p0;
  logic [W-1:0]   sq;
  logic [W-1:0]   res_p1;
  logic [W-1:0]   cnt_q;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      ops[k] = req_data[k*W +: W];
    end
  end

  // Scan from the highest offset down so the requester nearest ptr wins last.
  always_comb begin
    win     = ptr_q;
    idx     = '0;
    any_req = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = ptr_q + i[1:0];
      if (req_valid[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    res_valid  = 1'b0;
    busy       = (state_q != IDLE);
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        // rst_n gate keeps req_ready low while reset is held.
        if (rst_n && any_req) begin
          req_ready[win] = 1'b1;
          grant_fire     = 1'b1;
          state_d        = CALC;
        end
      end
      CALC: state_d = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          done_fire = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_fire) ptr_q <= win + 2'd1;
      if (done_fire)  cnt_q <= sat_inc(cnt_q);
    end
  end

  // Stage p0: operand and owner captured on the grant handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_p0 <= '0;
      id_p0 <= '0;
    end else if (grant_fire) begin
      op_p0 <= ops[win];
      id_p0 <= win;
    end
  end

  radix4_16 #(.W(W)) u_sq (
    .a  (op_p0),
    .sq (sq)
  );

  // Stage p1: squarer output registered in CALC and held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p1 <= '0;
    end else if (state_q == CALC) begin
      res_p1 <= sq;
    end
  end

  assign res_id   = id_p0;
  assign res_data = res_p1;
  assign done_cnt = cnt_q;

endmodule

// File: tb/tb_square_arb4.sv
// Directed bench for square_arb4: grant, latency, squaring, round robin,
// back-pressure, mid-operation reset and counter saturation.
module tb_square_arb4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [1:0]  res_id;
  logic [15:0] res_data;
  logic        res_ready;
  logic        busy;
  logic [15:0] done_cnt;

  int checks = 0;
  int errors = 0;

  square_arb4 #(.W(16), .NREQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .res_ready (res_ready),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one cycle and park at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; req_data = 64'h0004_0003_0002_0001; res_ready = 1'b0;
    tick(); tick();
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL rst_res_id got %0d want 0", res_id); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL rst_res_data got %h want 0000", res_data); end
    checks++; if (done_cnt !== 16'h0000) begin errors++; $display("FAIL rst_done_cnt got %h want 0000", done_cnt); end
    req_valid = 4'b0000;
  endtask

  task automatic test_basic();
    @(negedge clk);
    rst_n = 1'b1; req_valid = 4'b0001; req_data = 64'h0000_0000_0000_1234; res_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_grant got %b want 0001", req_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy); end
    tick();
    req_valid = 4'b0000;
    #1;
    checks++; if (busy !== 1'b1 || res_valid !== 1'b0 || req_ready !== 4'b0000) begin
      errors++; $display("FAIL basic_calc got busy=%b vld=%b rdy=%b want 1 0 0000", busy, res_valid, req_ready); end
    tick();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_res_valid got %b want 1", res_valid); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL basic_res_id got %0d want 0", res_id); end
    checks++; if (res_data !== 16'h5A90) begin errors++; $display("FAIL basic_res_data got %h want 5a90", res_data); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_back_idle got vld=%b busy=%b want 0 0", res_valid, busy); end
    checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL basic_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_operands();
    logic [15:0] ops [3] = '{16'h00FF, 16'h0100, 16'hFFFF};
    logic [15:0] exp [3] = '{16'hFE01, 16'h0000, 16'h0001};
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0001 << (i + 1);
      req_data = '0;
      req_data[(i+1)*16 +: 16] = ops[i];
      #1;
      checks++; if (req_ready !== req_valid) begin errors++; $display("FAIL ops_grant[%0d] got %b want %b", i, req_ready, req_valid); end
      tick();
      req_valid = 4'b0000;
      tick();
      checks++; if (res_valid !== 1'b1 || res_id !== 2'(i + 1) || res_data !== exp[i]) begin
        errors++; $display("FAIL ops_result[%0d] got vld=%b id=%0d data=%h want 1 %0d %h", i, res_valid, res_id, res_data, i + 1, exp[i]); end
      tick();
    end
    res_ready = 1'b0;
    checks++; if (done_cnt !== 16'd4) begin errors++; $display("FAIL ops_done_cnt got %0d want 4", done_cnt); end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] sq [4] = '{16'd4, 16'd9, 16'd16, 16'd25};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111; req_data = 64'h0005_0004_0003_0002; res_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << order[n])) begin
        errors++; $display("FAIL rr_grant[%0d] got %b want %b", n, req_ready, 4'b0001 << order[n]); end
      tick();
      checks++; if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
        errors++; $display("FAIL rr_calc[%0d] got rdy=%b vld=%b want 0000 0", n, req_ready, res_valid); end
      tick();
      checks++; if (res_valid !== 1'b1 || res_id !== 2'(order[n]) || res_data !== sq[order[n]] || req_ready !== 4'b0000) begin
        errors++; $display("FAIL rr_result[%0d] got vld=%b id=%0d data=%h rdy=%b want 1 %0d %h 0000", n, res_valid, res_id, res_data, req_ready, order[n], sq[order[n]]); end
      tick();
    end
    req_valid = 4'b0000; res_ready = 1'b0;
    checks++; if (done_cnt !== 16'd5) begin errors++; $display("FAIL rr_done_cnt got %0d want 5", done_cnt); end
  endtask

  task automatic test_back_pressure();
    req_valid = 4'b1000; req_data = 64'hABCD_0000_0000_0000; res_ready = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++; if (res_valid !== 1'b1 || res_data !== 16'h8229 || res_id !== 2'd3 || req_ready !== 4'b0000 || busy !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d] got vld=%b data=%h id=%0d rdy=%b busy=%b want 1 8229 3 0000 1", c, res_valid, res_data, res_id, req_ready, busy); end
      tick();
    end
    req_valid = 4'b0000; res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (done_cnt !== 16'd6 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got cnt=%0d busy=%b want 6 0", done_cnt, busy); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_data = 64'h0000_0007_0000_0000; res_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_calc_busy got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0 || done_cnt !== 16'd0 || res_data !== 16'd0) begin
      errors++; $display("FAIL mid_async got busy=%b vld=%b cnt=%0d data=%h want 0 0 0 0000", busy, res_valid, done_cnt, res_data); end
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1010; req_data = 64'h0009_0000_0010_0000;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_next_grant got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_calc_valid got %b want 0", res_valid); end
    tick();
    checks++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 16'h0100) begin
      errors++; $display("FAIL mid_result got vld=%b id=%0d data=%h want 1 1 0100", res_valid, res_id, res_data); end
    tick();
    res_ready = 1'b0;
    checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL mid_done_cnt got %0d want 1", done_cnt); end
  endtask

  task automatic test_saturate();
    force dut.cnt_q = 16'hFFFF;
    #1;
    checks++; if (done_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_preset got %h want ffff", done_cnt); end
    tick();
    release dut.cnt_q;
    req_valid = 4'b0001; req_data = 64'h0000_0000_0000_0002; res_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    tick();
    checks++; if (res_valid !== 1'b1 || res_data !== 16'h0004) begin
      errors++; $display("FAIL sat_result got vld=%b data=%h want 1 0004", res_valid, res_data); end
    tick();
    res_ready = 1'b0;
    checks++; if (done_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", done_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b0;
    test_reset();
    test_basic();
    test_operands();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
